// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults and pixel types shared by the sink and sprite drawers
package vga_timing_pkg;
  localparam int VGA_PIX_DIV = 2;
  localparam int VGA_H_VIS = 640, VGA_H_FP = 16, VGA_H_SYNC = 96, VGA_H_BP = 48;
  localparam int VGA_V_VIS = 480, VGA_V_FP = 10, VGA_V_SYNC = 2, VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  typedef logic [5:0] rgb_t;
  typedef logic [9:0] coord_t;
  localparam rgb_t VGA_BG_COLOR = 6'b010111;
endpackage

// File: rtl/vga_pixel_sink_if.sv
// vga_pixel_sink_if: coordinate/sync/colour bundle between the pixel sink and the drawers/monitor side
interface vga_pixel_sink_if;
  import vga_timing_pkg::*;
  logic   draw;
  rgb_t   data;
  coord_t hcount, vcount;
  logic   pix_tick, frame_tick, hsync, vsync;
  rgb_t   rgb;
  modport master (input draw, data, output hcount, vcount, pix_tick, frame_tick, hsync, vsync, rgb);
  modport slave (output draw, data, input hcount, vcount, pix_tick, frame_tick, hsync, vsync, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel divider, h/v counters, frame tick and raw sync/visible decode
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = VGA_PIX_DIV,
  parameter int H_VIS = VGA_H_VIS, H_FP = VGA_H_FP, H_SYNC = VGA_H_SYNC, H_BP = VGA_H_BP,
  parameter int V_VIS = VGA_V_VIS, V_FP = VGA_V_FP, V_SYNC = VGA_V_SYNC, V_BP = VGA_V_BP
) (
  input  logic   clk,
  input  logic   rst_n,
  output coord_t o_hcount,
  output coord_t o_vcount,
  output logic   o_pix_tick,
  output logic   o_frame_tick,
  output logic   o_hsync_raw,
  output logic   o_vsync_raw,
  output logic   o_video_on
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  logic [DW-1:0] r_div;
  coord_t r_h, r_v;
  logic r_tick, r_ftick;
  logic w_wrap, w_h_end, w_v_end;
  assign w_wrap = r_div == DW'(PIX_DIV - 1);
  assign w_h_end = r_h == coord_t'(H_TOT - 1);
  assign w_v_end = r_v == coord_t'(V_TOT - 1);
  // pix_tick is registered alongside the counters so it is high while the new coordinates are shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_h <= '0;
      r_v <= '0;
      r_tick <= 1'b0;
      r_ftick <= 1'b0;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      r_tick <= w_wrap;
      r_ftick <= w_wrap && w_h_end && r_v == coord_t'(V_VIS - 1);
      if (w_wrap) begin
        r_h <= w_h_end ? '0 : r_h + 1'b1;
        if (w_h_end) r_v <= w_v_end ? '0 : r_v + 1'b1;
      end
    end
  end
  assign o_hcount = r_h;
  assign o_vcount = r_v;
  assign o_pix_tick = r_tick;
  assign o_frame_tick = r_ftick;
  assign o_hsync_raw = !(r_h >= coord_t'(H_VIS + H_FP) && r_h < coord_t'(H_VIS + H_FP + H_SYNC));
  assign o_vsync_raw = !(r_v >= coord_t'(V_VIS + V_FP) && r_v < coord_t'(V_VIS + V_FP + V_SYNC));
  assign o_video_on = (r_h < coord_t'(H_VIS)) && (r_v < coord_t'(V_VIS));
endmodule

// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: aligns syncs with the drawers' one-clk-late colour and muxes sprite/background/blank
module vga_pixel_sink
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = VGA_PIX_DIV,
  parameter int H_VIS = VGA_H_VIS, H_FP = VGA_H_FP, H_SYNC = VGA_H_SYNC, H_BP = VGA_H_BP,
  parameter int V_VIS = VGA_V_VIS, V_FP = VGA_V_FP, V_SYNC = VGA_V_SYNC, V_BP = VGA_V_BP,
  parameter rgb_t BG_COLOR = VGA_BG_COLOR
) (
  input logic clk,
  input logic rst_n,
  vga_pixel_sink_if.master bus
);
  logic w_tick, w_hs_raw, w_vs_raw, w_von;
  logic r_tick_d, r_hs_d, r_vs_d, r_von_d, r_hs, r_vs;
  rgb_t r_rgb;
  vga_timing_gen #(
    .PIX_DIV(PIX_DIV),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_gen (
    .clk(clk),
    .rst_n(rst_n),
    .o_hcount(bus.hcount),
    .o_vcount(bus.vcount),
    .o_pix_tick(w_tick),
    .o_frame_tick(bus.frame_tick),
    .o_hsync_raw(w_hs_raw),
    .o_vsync_raw(w_vs_raw),
    .o_video_on(w_von)
  );
  // stage 1 waits out the drawers' register, stage 2 lands syncs and colour on one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_d <= 1'b0;
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
      r_von_d <= 1'b0;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_rgb <= '0;
    end else begin
      r_tick_d <= w_tick;
      if (w_tick) begin
        r_hs_d <= w_hs_raw;
        r_vs_d <= w_vs_raw;
        r_von_d <= w_von;
      end
      if (r_tick_d) begin
        r_hs <= r_hs_d;
        r_vs <= r_vs_d;
        r_rgb <= !r_von_d ? '0 : bus.draw ? bus.data : BG_COLOR;
      end
    end
  end
  assign bus.pix_tick = w_tick;
  assign bus.hsync = r_hs;
  assign bus.vsync = r_vs;
  assign bus.rgb = r_rgb;
endmodule
